// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and serial line levels,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uartState_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // A prescale of zero would never finish a bit, so it runs as one clk per bit.
    function automatic logic [5:0] effectivePrescale(input logic [5:0] prescale);
        return (prescale == 6'd0) ? 6'd1 : prescale;
    endfunction

endpackage

// File: rtl/uart_tx_top_if.sv
// Transmit-side bundle: parallel request, frame options and serial output.
interface uart_tx_top_if #(
    parameter int dataWidth = 8
);
    logic [dataWidth-1:0] p_data;
    logic                 data_valid;
    logic                 par_en;
    logic                 par_type;
    logic [5:0]           prescale;
    logic                 tx_out;
    logic                 busy;

    modport master (
        output p_data, data_valid, par_en, par_type, prescale,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_type, prescale,
        output tx_out, busy
    );
endinterface

// File: rtl/uart_tx_top_parity_calc.sv
// Parity of a data word: plain XOR for even parity, inverted XOR for odd.
module uartTx_parity_calc #(
    parameter int dataWidth = 8
) (
    input  logic [dataWidth-1:0] data_i,
    input  logic                 parType_i,
    output logic                 parityBit_o
);
    assign parityBit_o = (^data_i) ^ parType_i;
endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: latches a word and its frame options on acceptance, then
// shifts out start, data (LSB first), optional parity and stop bits.
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int dataWidth = 8
) (
    input logic         clk,
    input logic         rst,
    uart_tx_top_if.slave bus
);
    localparam int bitCntWidth = (dataWidth > 1) ? $clog2(dataWidth) : 1;
    localparam logic [bitCntWidth-1:0] lastBit = bitCntWidth'(dataWidth - 1);

    uartState_e             state_q, state_d;
    logic [5:0]             edgeCnt_q, edgeCnt_d;
    logic [bitCntWidth-1:0] bitCnt_q, bitCnt_d;
    logic [dataWidth-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [5:0]             prescale_q, prescale_d;
    logic                   parEn_q, parEn_d;
    logic                   txOut_q, txOut_d;
    logic                   busy_q, busy_d;
    logic                   parityBit;
    logic                   lastEdge;

    uartTx_parity_calc #(.dataWidth(dataWidth)) parityCalc (
        .data_i      (bus.p_data),
        .parType_i   (bus.par_type),
        .parityBit_o (parityBit)
    );

    assign lastEdge = (edgeCnt_q == prescale_q - 6'd1);

    // txOut_d is the level for the upcoming bit, so the line itself is a flop.
    always_comb begin
        state_d    = state_q;
        edgeCnt_d  = edgeCnt_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        prescale_d = prescale_q;
        parEn_d    = parEn_q;
        txOut_d    = txOut_q;
        busy_d     = busy_q;

        if (state_q == IDLE) begin
            txOut_d = IDLE_LEVEL;
            busy_d  = 1'b0;
            if (bus.data_valid && !busy_q) begin
                shift_d    = bus.p_data;
                parity_d   = parityBit;
                prescale_d = effectivePrescale(bus.prescale);
                parEn_d    = bus.par_en;
                edgeCnt_d  = 6'd0;
                bitCnt_d   = '0;
                state_d    = START;
                txOut_d    = START_LEVEL;
                busy_d     = 1'b1;
            end
        end else if (!lastEdge) begin
            edgeCnt_d = edgeCnt_q + 6'd1;
        end else begin
            edgeCnt_d = 6'd0;
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    txOut_d = shift_q[0];
                end
                DATA: begin
                    if (bitCnt_q == lastBit) begin
                        state_d = parEn_q ? PARITY : STOP;
                        txOut_d = parEn_q ? parity_q : STOP_LEVEL;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                        shift_d  = shift_q >> 1;
                        txOut_d  = shift_d[0];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    txOut_d = STOP_LEVEL;
                end
                default: begin
                    state_d = IDLE;
                    txOut_d = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            edgeCnt_q  <= 6'd0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            prescale_q <= 6'd0;
            parEn_q    <= 1'b0;
            txOut_q    <= IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edgeCnt_q  <= edgeCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            prescale_q <= prescale_d;
            parEn_q    <= parEn_d;
            txOut_q    <= txOut_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.tx_out = txOut_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: frame shapes, parity, back-to-back frames,
// ignored mid-frame requests, reset abort and prescale zero.
module tb_uart_tx_top;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic txLog[0:1023];

    uart_tx_top_if #(.dataWidth(8)) bus ();

    uart_tx_top #(.dataWidth(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level of frame bit idx: start, 8 data LSB first, parity, stop.
    function automatic logic expBit(input logic [7:0] d, input logic pe, input logic pt, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && pe) return (^d) ^ pt;
        return 1'b1;
    endfunction

    // Logs tx_out each cycle while busy; optionally disturbs inputs at one cycle.
    task automatic captureFrame(input int disturbAt, output int nBusy);
        for (int i = 0; i < 1024; i++) txLog[i] = 1'bx;
        nBusy = 0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.busy !== 1'b1) break;
            txLog[c] = bus.tx_out;
            nBusy = c + 1;
            if (disturbAt >= 0 && c == disturbAt) begin
                bus.p_data     = 8'h00;
                bus.prescale   = 6'd2;
                bus.data_valid = 1'b1;
            end else if (disturbAt >= 0 && c == disturbAt + 1) begin
                bus.data_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic startFrame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] pre);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_type   = pt;
        bus.prescale   = pre;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        bus.data_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.tx_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_tx_out: got %b expected 1", bus.tx_out);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        end
        bus.data_valid = 1'b0;
        rst            = 1'b1;
        tick();
    endtask

    task automatic test_even_parity();
        int n;
        startFrame(8'hA5, 1'b1, 1'b0, 6'd8);
        captureFrame(-1, n);
        checks++;
        if (n !== 88) begin
            errors++;
            $display("[TB] FAIL a5_busy_len: got %0d expected 88", n);
        end
        for (int b = 0; b < 11; b++) begin
            logic bad;
            bad = 1'b0;
            for (int k = 0; k < 8; k++)
                if (txLog[b*8+k] !== expBit(8'hA5, 1'b1, 1'b0, b)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("[TB] FAIL a5_bit%0d: got %b expected %b", b, txLog[b*8], expBit(8'hA5, 1'b1, 1'b0, b));
            end
        end
        checks++;
        if (bus.tx_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL a5_idle_after: got %b expected 1", bus.tx_out);
        end
        tick();
    endtask

    task automatic test_odd_parity();
        int n;
        startFrame(8'h01, 1'b1, 1'b1, 6'd16);
        captureFrame(-1, n);
        checks++;
        if (n !== 176) begin
            errors++;
            $display("[TB] FAIL odd_busy_len: got %0d expected 176", n);
        end
        for (int b = 0; b < 11; b++) begin
            logic bad;
            bad = 1'b0;
            for (int k = 0; k < 16; k++)
                if (txLog[b*16+k] !== expBit(8'h01, 1'b1, 1'b1, b)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("[TB] FAIL odd_bit%0d: got %b expected %b", b, txLog[b*16], expBit(8'h01, 1'b1, 1'b1, b));
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        int quiet;
        bus.p_data     = 8'hFF;
        bus.par_en     = 1'b0;
        bus.par_type   = 1'b0;
        bus.prescale   = 6'd4;
        bus.data_valid = 1'b1;
        tick();
        captureFrame(-1, n1);
        checks++;
        if (n1 !== 40) begin
            errors++;
            $display("[TB] FAIL b2b_len1: got %0d expected 40", n1);
        end
        for (int b = 0; b < 10; b++) begin
            logic bad;
            bad = 1'b0;
            for (int k = 0; k < 4; k++)
                if (txLog[b*4+k] !== expBit(8'hFF, 1'b0, 1'b0, b)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("[TB] FAIL b2b_bit%0d: got %b expected %b", b, txLog[b*4], expBit(8'hFF, 1'b0, 1'b0, b));
            end
        end
        checks++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_gap: got tx=%b busy=%b expected tx=1 busy=0", bus.tx_out, bus.busy);
        end
        tick();
        checks++;
        if (bus.tx_out !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_restart: got tx=%b busy=%b expected tx=0 busy=1", bus.tx_out, bus.busy);
        end
        captureFrame(-1, n2);
        bus.data_valid = 1'b0;
        checks++;
        if (n2 !== 40) begin
            errors++;
            $display("[TB] FAIL b2b_len2: got %0d expected 40", n2);
        end
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.busy !== 1'b0) quiet++;
        end
        checks++;
        if (quiet !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_stop: got %0d busy cycles expected 0", quiet);
        end
    endtask

    task automatic test_ignore_changes();
        int n;
        int extra;
        startFrame(8'hA5, 1'b1, 1'b0, 6'd8);
        captureFrame(20, n);
        checks++;
        if (n !== 88) begin
            errors++;
            $display("[TB] FAIL ign_len: got %0d expected 88", n);
        end
        for (int b = 0; b < 11; b++) begin
            logic bad;
            bad = 1'b0;
            for (int k = 0; k < 8; k++)
                if (txLog[b*8+k] !== expBit(8'hA5, 1'b1, 1'b0, b)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("[TB] FAIL ign_bit%0d: got %b expected %b", b, txLog[b*8], expBit(8'hA5, 1'b1, 1'b0, b));
            end
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) extra++;
            tick();
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("[TB] FAIL ign_no_extra: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_midframe();
        int active;
        startFrame(8'hA5, 1'b1, 1'b0, 6'd8);
        for (int i = 0; i < 30; i++) tick();
        rst            = 1'b0;
        bus.data_valid = 1'b1;
        tick();
        checks++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_abort: got tx=%b busy=%b expected tx=1 busy=0", bus.tx_out, bus.busy);
        end
        rst            = 1'b1;
        bus.data_valid = 1'b0;
        active = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) active++;
        end
        checks++;
        if (active !== 0) begin
            errors++;
            $display("[TB] FAIL rst_quiet: got %0d active cycles expected 0", active);
        end
    endtask

    task automatic test_prescale_zero();
        int n;
        logic [9:0] expSeq;
        expSeq = 10'b1001111000;
        startFrame(8'h3C, 1'b0, 1'b0, 6'd0);
        captureFrame(-1, n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("[TB] FAIL pre0_len: got %0d expected 10", n);
        end
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (txLog[b] !== expSeq[b]) begin
                errors++;
                $display("[TB] FAIL pre0_bit%0d: got %b expected %b", b, txLog[b], expSeq[b]);
            end
        end
        tick();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        bus.p_data     = 8'h00;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_type   = 1'b0;
        bus.prescale   = 6'd1;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_back_to_back();
        test_ignore_changes();
        test_reset_midframe();
        test_prescale_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
